// File: rtl/repll_request.sv
// PLL reconfiguration request sequencer. Accepts a multiply/divide factor request, pulses the
// reconfiguration controller, waits for it to start and finish, then waits for a stable PLL lock
// and reports the result with a one-cycle done pulse and a held status code.
module repll_request #(
  parameter logic [7:0]  START_TIMEOUT = 8'd255,
  parameter logic [15:0] LOCK_TIMEOUT  = 16'd50000,
  parameter logic [3:0]  LOCK_STABLE   = 4'd4,
  parameter logic [7:0]  M_RESET       = 8'd1,
  parameter logic [7:0]  D_RESET       = 8'd1
) (
  input  logic       clock_ctr,
  input  logic       sys_reset,
  input  logic       req_valid,
  input  logic [7:0] req_mult,
  input  logic [7:0] req_div,
  output logic       req_ready,
  output logic [7:0] MultiFactor,
  output logic [7:0] DividFactor,
  output logic       trigger,
  input  logic       busy_ctr,
  input  logic       pll_locked,
  output logic       done,
  output logic [1:0] status
);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitBusy,
    StWaitIdle,
    StWaitLock,
    StReport
  } state_e;

  localparam logic [1:0] StatusOk           = 2'b00;
  localparam logic [1:0] StatusRejected     = 2'b01;
  localparam logic [1:0] StatusLockTimeout  = 2'b10;
  localparam logic [1:0] StatusStartTimeout = 2'b11;

  state_e      state_q, state_d;
  logic [7:0]  mult_q, mult_d;
  logic [7:0]  div_q, div_d;
  logic [1:0]  status_q, status_d;
  logic [7:0]  start_cnt_q, start_cnt_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;
  logic [3:0]  stable_cnt_q, stable_cnt_d;
  logic        ready_q, trigger_q, done_q;

  // Saturating increments; stable_inc also folds in the clear-on-unlock rule.
  logic [7:0]  start_inc;
  logic [15:0] lock_inc;
  logic [3:0]  stable_inc;

  // Next-state, factor, status and counter logic.
  always_comb begin
    state_d      = state_q;
    mult_d       = mult_q;
    div_d        = div_q;
    status_d     = status_q;
    start_cnt_d  = start_cnt_q;
    lock_cnt_d   = lock_cnt_q;
    stable_cnt_d = stable_cnt_q;
    start_inc    = (start_cnt_q == 8'hFF) ? start_cnt_q : start_cnt_q + 8'd1;
    lock_inc     = (lock_cnt_q == 16'hFFFF) ? lock_cnt_q : lock_cnt_q + 16'd1;
    stable_inc   = 4'd0;
    if (pll_locked) begin
      stable_inc = (stable_cnt_q == 4'hF) ? stable_cnt_q : stable_cnt_q + 4'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (req_valid && ready_q) begin
          if ((req_mult == 8'd0) || (req_div == 8'd0)) begin
            status_d = StatusRejected;
            state_d  = StReport;
          end else begin
            mult_d  = req_mult;
            div_d   = req_div;
            state_d = StTrig;
          end
        end
      end
      StTrig: begin
        start_cnt_d = 8'd0;
        state_d     = StWaitBusy;
      end
      StWaitBusy: begin
        if (busy_ctr) begin
          state_d = StWaitIdle;
        end else begin
          start_cnt_d = start_inc;
          if (start_inc >= START_TIMEOUT) begin
            status_d = StatusStartTimeout;
            state_d  = StReport;
          end
        end
      end
      StWaitIdle: begin
        // The controller may take arbitrarily long once it has started.
        if (!busy_ctr) begin
          lock_cnt_d   = 16'd0;
          stable_cnt_d = 4'd0;
          state_d      = StWaitLock;
        end
      end
      StWaitLock: begin
        stable_cnt_d = stable_inc;
        lock_cnt_d   = lock_inc;
        // A lock that completes on the timeout cycle still counts as success.
        if (stable_inc >= LOCK_STABLE) begin
          status_d = StatusOk;
          state_d  = StReport;
        end else if (lock_inc >= LOCK_TIMEOUT) begin
          status_d = StatusLockTimeout;
          state_d  = StReport;
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, data and registered output flops with synchronous reset.
  always_ff @(posedge clock_ctr) begin
    if (sys_reset) begin
      state_q      <= StIdle;
      mult_q       <= M_RESET;
      div_q        <= D_RESET;
      status_q     <= StatusOk;
      start_cnt_q  <= 8'd0;
      lock_cnt_q   <= 16'd0;
      stable_cnt_q <= 4'd0;
      ready_q      <= 1'b1;
      trigger_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mult_q       <= mult_d;
      div_q        <= div_d;
      status_q     <= status_d;
      start_cnt_q  <= start_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      // Strobes decoded from the next state so they line up with the state register.
      ready_q      <= (state_d == StIdle);
      trigger_q    <= (state_d == StTrig);
      done_q       <= (state_d == StReport);
    end
  end

  assign req_ready   = ready_q;
  assign MultiFactor = mult_q;
  assign DividFactor = div_q;
  assign trigger     = trigger_q;
  assign done        = done_q;
  assign status      = status_q;

endmodule

// File: tb/tb_repll_request.sv
// Bench for repll_request: drives busy/lock waveforms described by a few scenario parameters and
// predicts done timing and status from the sequencing rules with a cycle-indexed model.
module tb_repll_request;

  localparam int StTo = 255;    // start timeout cycles
  localparam int LkTo = 50000;  // lock timeout cycles
  localparam int LkSt = 4;      // consecutive locked cycles needed

  logic       clock_ctr;
  logic       sys_reset;
  logic       req_valid;
  logic [7:0] req_mult;
  logic [7:0] req_div;
  logic       req_ready;
  logic [7:0] MultiFactor;
  logic [7:0] DividFactor;
  logic       trigger;
  logic       busy_ctr;
  logic       pll_locked;
  logic       done;
  logic [1:0] status;

  int checks = 0;
  int errors = 0;

  // Expected held state between transactions.
  logic [7:0] exp_m = 8'd1;
  logic [7:0] exp_d = 8'd1;
  logic [1:0] exp_status = 2'b00;

  // Scenario, indexed by cycle n after the accept edge (trigger cycle is n = 0).
  int b0 = 1;     // first busy cycle
  int blen = 1;   // busy length
  int lk = 0;     // first locked cycle
  int lmode = 0;  // 0 steady lock, 1 pattern 1,1,1,0, 2 steady with one dropout
  int gl = 0;     // dropout offset for mode 2

  repll_request dut (
    .clock_ctr  (clock_ctr),
    .sys_reset  (sys_reset),
    .req_valid  (req_valid),
    .req_mult   (req_mult),
    .req_div    (req_div),
    .req_ready  (req_ready),
    .MultiFactor(MultiFactor),
    .DividFactor(DividFactor),
    .trigger    (trigger),
    .busy_ctr   (busy_ctr),
    .pll_locked (pll_locked),
    .done       (done),
    .status     (status)
  );

  initial clock_ctr = 1'b0;
  always #5 clock_ctr = ~clock_ctr;

  function automatic bit busy_at(input int c);
    return (c >= b0) && (c < b0 + blen);
  endfunction

  function automatic bit lock_at(input int c);
    if (c < lk) return 1'b0;
    case (lmode)
      1:       return ((c - lk) % 4) != 3;
      2:       return c != lk + gl;
      default: return 1'b1;
    endcase
  endfunction

  // Done cycle and status implied by the scenario.
  function automatic void predict(input bit rej, output int done_c, output logic [1:0] st);
    int l;
    int run;
    if (rej) begin
      done_c = 0;
      st = 2'b01;
      return;
    end
    // Waiting for busy covers cycles 1..StTo.
    if (b0 > StTo) begin
      done_c = StTo + 1;
      st = 2'b11;
      return;
    end
    l = b0 + blen + 1;  // first lock-wait cycle
    run = 0;
    for (int c = l; c < l + LkTo; c++) begin
      run = lock_at(c) ? run + 1 : 0;
      if (run >= LkSt) begin
        done_c = c + 1;
        st = 2'b00;
        return;
      end
    end
    done_c = l + LkTo;
    st = 2'b10;
  endfunction

  // One request; abort_at >= 0 stops observation at that cycle without expecting done.
  task automatic run_txn(input string name, input logic [7:0] m, input logic [7:0] d,
                         input bit hold, input int abort_at);
    int exp_done, got_done, trig_cnt, bad_trig, bad_ready, bad_fact, bad_hold, limit;
    logic [1:0] exp_st, got_st;
    logic [7:0] fm, fd;
    bit rej;
    rej = (m == 8'd0) || (d == 8'd0);
    predict(rej, exp_done, exp_st);
    fm = rej ? exp_m : m;
    fd = rej ? exp_d : d;
    limit = (abort_at >= 0) ? abort_at : exp_done + 4;
    got_done = -1;
    got_st = 2'b00;
    trig_cnt = 0;
    bad_trig = 0;
    bad_ready = 0;
    bad_fact = 0;
    bad_hold = 0;
    @(negedge clock_ctr);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b expected 1", name, req_ready);
    end
    req_valid = 1'b1;
    req_mult = m;
    req_div = d;
    busy_ctr = 1'b0;
    pll_locked = 1'b0;
    for (int n = 0; n <= limit; n++) begin
      @(negedge clock_ctr);
      if (trigger === 1'b1) begin
        trig_cnt++;
        if (n != 0) bad_trig++;
      end
      if (req_ready !== 1'b0) bad_ready++;
      if (MultiFactor !== fm || DividFactor !== fd) bad_fact++;
      if (done === 1'b1) begin
        got_done = n;
        got_st = status;
        break;
      end
      if (status !== exp_status) bad_hold++;
      busy_ctr = busy_at(n);
      pll_locked = lock_at(n);
      if (!hold) req_valid = 1'b0;
      else begin
        req_mult = 8'($urandom);
        req_div = 8'($urandom);
      end
      if (abort_at >= 0 && n == abort_at) break;
    end
    checks++;
    if (trig_cnt != (rej ? 0 : 1)) begin
      errors++;
      $display("FAIL %s trigger_count: got %0d expected %0d", name, trig_cnt, rej ? 0 : 1);
    end
    checks++;
    if (bad_trig != 0) begin
      errors++;
      $display("FAIL %s trigger_position: got %0d late pulses expected 0", name, bad_trig);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL %s ready_while_busy: got %0d cycles expected 0", name, bad_ready);
    end
    checks++;
    if (bad_fact != 0) begin
      errors++;
      $display("FAIL %s factors: got %0d bad cycles (last %0d/%0d) expected %0d/%0d", name,
               bad_fact, MultiFactor, DividFactor, fm, fd);
    end
    checks++;
    if (bad_hold != 0) begin
      errors++;
      $display("FAIL %s status_hold: got %0d bad cycles expected 0", name, bad_hold);
    end
    if (abort_at < 0) begin
      checks++;
      if (got_done != exp_done) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d expected %0d", name, got_done, exp_done);
      end
      checks++;
      if (got_st !== exp_st) begin
        errors++;
        $display("FAIL %s status: got %b expected %b", name, got_st, exp_st);
      end
      exp_status = exp_st;
    end else begin
      checks++;
      if (got_done != -1) begin
        errors++;
        $display("FAIL %s done_before_abort: got cycle %0d expected none", name, got_done);
      end
    end
    if (!rej) begin
      exp_m = m;
      exp_d = d;
    end
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    repeat (3) @(negedge clock_ctr);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    checks++;
    if (trigger !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_strobes: got trigger=%b done=%b expected 0/0", trigger, done);
    end
    checks++;
    if (MultiFactor !== 8'd1 || DividFactor !== 8'd1) begin
      errors++;
      $display("FAIL reset_factors: got %0d/%0d expected 1/1", MultiFactor, DividFactor);
    end
    checks++;
    if (status !== 2'b00) begin
      errors++;
      $display("FAIL reset_status: got %b expected 00", status);
    end
    sys_reset = 1'b0;
    @(negedge clock_ctr);
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready=%b done=%b expected 1/0", req_ready, done);
    end
  endtask

  task automatic test_nominal();
    b0 = 3; blen = 40; lmode = 0; lk = b0 + blen + 4;
    run_txn("nominal", 8'd12, 8'd5, 1'b0, -1);
  endtask

  task automatic test_reject();
    run_txn("reject_m0", 8'd0, 8'd3, 1'b0, -1);
    run_txn("reject_d0", 8'd9, 8'd0, 1'b0, -1);
  endtask

  task automatic test_start_timeout();
    b0 = 100000; blen = 1; lmode = 0; lk = 0;
    run_txn("start_timeout", 8'd33, 8'd7, 1'b0, -1);
    // Busy arriving on the last allowed cycle still starts the sequence.
    b0 = StTo; blen = 2; lmode = 0; lk = 0;
    run_txn("start_edge", 8'd44, 8'd2, 1'b0, -1);
    b0 = StTo + 1;
    run_txn("start_edge_late", 8'd45, 8'd3, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [7:0] m, d;
    for (int i = 0; i < 12; i++) begin
      b0 = int'($urandom_range(1, 40));
      blen = int'($urandom_range(1, 30));
      lmode = int'($urandom_range(0, 1)) * 2;
      lk = b0 + int'($urandom_range(0, 50));
      gl = int'($urandom_range(0, 5));
      m = 8'($urandom_range(1, 255));
      d = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) m = 8'd0;
      run_txn($sformatf("random%0d", i), m, d, 1'b0, -1);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      b0 = int'($urandom_range(1, 10));
      blen = int'($urandom_range(1, 10));
      lmode = 0;
      lk = b0 + blen + int'($urandom_range(1, 6));
      run_txn($sformatf("b2b%0d", i), 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)),
              1'b1, -1);
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    run_txn("pre_abort_reject", 8'd0, 8'd0, 1'b0, -1);
    b0 = 2; blen = 5; lmode = 0; lk = 1000000;
    run_txn("abort", 8'd77, 8'd66, 1'b0, 20);
    sys_reset = 1'b1;
    busy_ctr = 1'b0;
    pll_locked = 1'b0;
    @(negedge clock_ctr);
    checks++;
    if (done !== 1'b0 || trigger !== 1'b0) begin
      errors++;
      $display("FAIL abort_strobes: got done=%b trigger=%b expected 0/0", done, trigger);
    end
    checks++;
    if (MultiFactor !== 8'd1 || DividFactor !== 8'd1) begin
      errors++;
      $display("FAIL abort_factors: got %0d/%0d expected 1/1", MultiFactor, DividFactor);
    end
    checks++;
    if (status !== 2'b00) begin
      errors++;
      $display("FAIL abort_status: got %b expected 00", status);
    end
    sys_reset = 1'b0;
    @(negedge clock_ctr);
    checks++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: got ready=%b done=%b expected 1/0", req_ready, done);
    end
    exp_m = 8'd1;
    exp_d = 8'd1;
    exp_status = 2'b00;
    b0 = 4; blen = 3; lmode = 0; lk = 9;
    run_txn("post_abort", 8'd21, 8'd8, 1'b0, -1);
  endtask

  task automatic test_lock_timeout();
    b0 = 2; blen = 6; lmode = 1; lk = b0 + blen + 1;
    run_txn("lock_timeout", 8'd50, 8'd4, 1'b0, -1);
  endtask

  initial begin
    sys_reset = 1'b1;
    req_valid = 1'b0;
    req_mult = 8'd0;
    req_div = 8'd0;
    busy_ctr = 1'b0;
    pll_locked = 1'b0;
    test_reset();
    test_nominal();
    test_reject();
    test_start_timeout();
    test_random();
    test_back_to_back();
    test_reset_abort();
    test_lock_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/repll_request.md
REPLL_REQUEST -- requirements
Module: repll_request

Interface
REQ-001 Parameter: START_TIMEOUT, default 8'd255, max cycles to wait for busy_ctr to rise after trigger.
REQ-002 Parameter: LOCK_TIMEOUT, default 16'd50000, max cycles to wait for stable lock after busy_ctr falls.
REQ-003 Parameter: LOCK_STABLE, default 4'd4, consecutive cycles pll_locked must be high to count as locked.
REQ-004 Parameter: M_RESET / D_RESET, default 8'd1 / 8'd1, factor values after reset.
REQ-005 Port: clock_ctr  in  1  sole clock, all logic on rising edge.
REQ-006 Port: sys_reset  in  1  reset, synchronous, active-high.
REQ-007 Port: req_valid  in  1  new factor request present.
REQ-008 Port: req_mult  in  8  requested multiply factor.
REQ-009 Port: req_div  in  8  requested divide factor.
REQ-010 Port: req_ready  out  1  block accepts a request this cycle.
REQ-011 Port: MultiFactor  out  8  registered multiply factor to the reconfig controller.
REQ-012 Port: DividFactor  out  8  registered divide factor to the reconfig controller.
REQ-013 Port: trigger  out  1  one-cycle start pulse to the reconfig controller.
REQ-014 Port: busy_ctr  in  1  reconfiguration-in-progress status.
REQ-015 Port: pll_locked  in  1  PLL lock indicator, already synchronous to clock_ctr.
REQ-016 Port: done  out  1  one-cycle completion pulse.
REQ-017 Port: status  out  2  result code: 00 ok, 01 rejected, 10 lock timeout, 11 start timeout.

Function
REQ-018 States SHALL be IDLE, TRIG, WAIT_BUSY, WAIT_IDLE, WAIT_LOCK, REPORT; state register and all outputs registered.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake completes when req_valid and req_ready both 1 on a rising edge.
REQ-020 On accept with req_mult==0 or req_div==0: factors unchanged, status<=01, next state REPORT.
REQ-021 On accept with both nonzero: MultiFactor<=req_mult, DividFactor<=req_div (same edge), next state TRIG.
REQ-022 TRIG: trigger=1 for exactly one cycle; next state WAIT_BUSY; factors stable from TRIG until return to IDLE.
REQ-023 WAIT_BUSY: busy_ctr==1 -> WAIT_IDLE; else cycle counter increments; counter reaching START_TIMEOUT -> status<=11, REPORT.
REQ-024 WAIT_IDLE: busy_ctr==0 -> WAIT_LOCK with timeout and stable counters cleared; no timeout in this state.
REQ-025 WAIT_LOCK: stable counter increments while pll_locked==1, clears to 0 on any pll_locked==0 cycle.
REQ-026 WAIT_LOCK: stable counter reaching LOCK_STABLE -> status<=00, REPORT; lock check takes priority over timeout on the same cycle.
REQ-027 WAIT_LOCK: 16-bit timeout counter reaching LOCK_TIMEOUT without stable lock -> status<=10, REPORT.
REQ-028 REPORT: done=1 for exactly one cycle; next state IDLE; status held until the next REPORT.
REQ-029 Latency: valid accept -> trigger high 1 cycle later; rejected request -> done 1 cycle after accept.
REQ-030 Counters SHALL saturate, never wrap; every counter cleared on entry to the state that uses it.
REQ-031 req_valid outside IDLE SHALL be ignored and not stored; trigger SHALL never assert outside TRIG.

Reset
REQ-032 sys_reset high at an edge: state<=IDLE, MultiFactor<=M_RESET, DividFactor<=D_RESET, status<=00, trigger=0, done=0, counters<=0.
REQ-033 Reset mid-operation SHALL abort without done pulse; req_ready=1 on the first cycle after reset deasserts.

Verification
REQ-034 Req M=8'd12 D=8'd5; busy_ctr high 3 cycles after trigger for 40 cycles; pll_locked high 4 cycles later -> MultiFactor=12, DividFactor=5, one trigger, done with status=00.
REQ-035 Req M=8'd0 D=8'd3 -> no trigger, factors stay at previous values, done next cycle with status=01.
REQ-036 Valid req, busy_ctr held 0 -> done after 255 WAIT_BUSY cycles, status=11.
REQ-037 Valid req, busy cycle completes, pll_locked toggles 1,1,1,0 repeatedly -> no stable lock; done after 50000 cycles, status=10.
REQ-038 sys_reset pulsed during WAIT_LOCK -> no done; MultiFactor=1, DividFactor=1, status=00; next req accepted normally.
REQ-039 req_valid held high during an active request -> exactly one trigger per accepted request; second request accepted only after done.
